// File: rtl/fatori_fault_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fatori_fault_pkg
// Purpose  : Shared types and helpers for the fault aggregator.
//            - Read-select codes.
//            - Alarm state encoding.
//            - Popcount helper.
//            - Saturating-add helper.
// Revision : 1.0 - initial release
// ============================================================================
package fatori_fault_pkg;

    // Counter select codes presented on rd_sel_i.
    typedef enum logic [2:0] {
        RD_MIN       = 3'd0,
        RD_MAJ       = 3'd1,
        RD_SCRUB     = 3'd2,
        RD_TOT_MIN   = 3'd3,
        RD_TOT_MAJ   = 3'd4,
        RD_TOT_SCRUB = 3'd5,
        RD_STATUS    = 3'd6,
        RD_NONE      = 3'd7
    } rd_sel_e;

    // Alarm FSM encoding. The encoding is also visible through the status read.
    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ALARM  = 2'd1,
        ST_ACKED  = 2'd2
    } alarm_st_e;

    // Wide enough to count up to 64 lanes.
    localparam int unsigned c_POP_W = 7;

    // Number of set bits in a vector of up to 64 lanes.
    function automatic logic [c_POP_W-1:0] popcount(input logic [63:0] v);
        logic [c_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + c_POP_W'(v[i]);
        end
        return n;
    endfunction

    // a + b clamped to the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] lim;
        logic [64:0] s;
        lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        s   = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage : fatori_fault_pkg
`default_nettype wire

// File: rtl/fatori_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : fatori_sat_cnt
// Purpose  : Saturating accumulator. Adds i_inc every cycle and sticks at
//            all-ones instead of wrapping. i_clr clears synchronously and
//            wins over the increment.
// Ports    : clk_i, arst_n_i (async active-low reset)
//            i_clr      - synchronous clear
//            i_inc      - increment amount (INC_W bits)
//            o_cnt      - current count (W bits)
// Revision : 1.0 - initial release
// ============================================================================
module fatori_sat_cnt
    import fatori_fault_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             i_clr,
    input  logic [INC_W-1:0] i_inc,
    output logic [W-1:0]     o_cnt
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_next;

    assign w_next = W'(sat_add(64'(r_cnt), 64'(i_inc), W));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule : fatori_sat_cnt
`default_nettype wire

// File: rtl/fatori_fault_aggr.sv
`default_nettype none
// ============================================================================
// Module   : fatori_fault_aggr
// Purpose  : Aggregates per-monitor error pulses into three kinds of state:
//            - saturating per-lane and global counters;
//            - sticky per-lane major flags;
//            - a level alarm interrupt with an acknowledge.
//            Counters are read through a 1-cycle-latency read port.
// Macro    : FATORI_FAULT_AGGR_SCRUB_CNT_EN - builds the scrub counters.
//            When it is undefined, scrub_pulse_i is ignored and selects
//            2 and 5 read 0.
// Ports    : clk_i, arst_n_i (async active-low reset)
//            min/maj/scrub_pulse_i - per-lane event pulses
//            clr_i                 - clear counters, stickies and alarm
//            rd_req_i/rd_sel_i/rd_idx_i -> rd_valid_o/rd_data_o
//            maj_sticky_o          - per-lane major-seen flags
//            irq_o / irq_ack_i     - alarm interrupt and acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module fatori_fault_aggr
    import fatori_fault_pkg::*;
#(
    parameter int unsigned NUM_MON = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TOT_W   = CNT_W + $clog2(NUM_MON + 1),
    parameter int unsigned MAJ_THR = 1
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic [NUM_MON-1:0] min_pulse_i,
    input  logic [NUM_MON-1:0] maj_pulse_i,
    input  logic [NUM_MON-1:0] scrub_pulse_i,
    input  logic               clr_i,
    input  logic               rd_req_i,
    input  logic [2:0]         rd_sel_i,
    input  logic [5:0]         rd_idx_i,
    output logic               rd_valid_o,
    output logic [TOT_W-1:0]   rd_data_o,
    output logic [NUM_MON-1:0] maj_sticky_o,
    output logic               irq_o,
    input  logic               irq_ack_i
);

    localparam int unsigned IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;

    // ------------------------------------------------------------------
    // Per-lane counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_min_cnt [NUM_MON];
    logic [CNT_W-1:0] w_maj_cnt [NUM_MON];

    for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_lane
        fatori_sat_cnt #(.W(CNT_W), .INC_W(1)) u_min_cnt (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .i_clr    (clr_i),
            .i_inc    (min_pulse_i[gi]),
            .o_cnt    (w_min_cnt[gi])
        );
        fatori_sat_cnt #(.W(CNT_W), .INC_W(1)) u_maj_cnt (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .i_clr    (clr_i),
            .i_inc    (maj_pulse_i[gi]),
            .o_cnt    (w_maj_cnt[gi])
        );
    end

    // ------------------------------------------------------------------
    // Global totals
    // ------------------------------------------------------------------
    logic [c_POP_W-1:0] w_pop_min;
    logic [c_POP_W-1:0] w_pop_maj;
    logic [TOT_W-1:0]   w_tot_min;
    logic [TOT_W-1:0]   w_tot_maj;
    logic [TOT_W-1:0]   w_tot_maj_next;
    logic               w_maj_any;

    assign w_pop_min = popcount(64'(min_pulse_i));
    assign w_pop_maj = popcount(64'(maj_pulse_i));
    assign w_maj_any = |maj_pulse_i;

    fatori_sat_cnt #(.W(TOT_W), .INC_W(c_POP_W)) u_tot_min (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .i_clr    (clr_i),
        .i_inc    (w_pop_min),
        .o_cnt    (w_tot_min)
    );

    fatori_sat_cnt #(.W(TOT_W), .INC_W(c_POP_W)) u_tot_maj (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .i_clr    (clr_i),
        .i_inc    (w_pop_maj),
        .o_cnt    (w_tot_maj)
    );

    // The alarm threshold is judged on the value the total is about to take,
    // so irq_o rises one edge after the pulse that reaches MAJ_THR.
    assign w_tot_maj_next = TOT_W'(sat_add(64'(w_tot_maj), 64'(w_pop_maj), TOT_W));

`ifdef FATORI_FAULT_AGGR_SCRUB_CNT_EN
    // ------------------------------------------------------------------
    // Scrub counters (optional)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   w_scrub_cnt [NUM_MON];
    logic [TOT_W-1:0]   w_tot_scrub;
    logic [c_POP_W-1:0] w_pop_scrub;

    assign w_pop_scrub = popcount(64'(scrub_pulse_i));

    for (genvar gs = 0; gs < NUM_MON; gs++) begin : g_scrub_lane
        fatori_sat_cnt #(.W(CNT_W), .INC_W(1)) u_scrub_cnt (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .i_clr    (clr_i),
            .i_inc    (scrub_pulse_i[gs]),
            .o_cnt    (w_scrub_cnt[gs])
        );
    end

    fatori_sat_cnt #(.W(TOT_W), .INC_W(c_POP_W)) u_tot_scrub (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .i_clr    (clr_i),
        .i_inc    (w_pop_scrub),
        .o_cnt    (w_tot_scrub)
    );
`else
    // Scrub pulses have no destination in this build.
    logic w_unused_scrub;
    assign w_unused_scrub = ^scrub_pulse_i;
`endif

    // ------------------------------------------------------------------
    // Sticky major flags
    // ------------------------------------------------------------------
    logic [NUM_MON-1:0] r_maj_sticky;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_maj_sticky <= '0;
        end else if (clr_i) begin
            r_maj_sticky <= '0;
        end else begin
            r_maj_sticky <= r_maj_sticky | maj_pulse_i;
        end
    end

    assign maj_sticky_o = r_maj_sticky;

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    alarm_st_e r_state;
    alarm_st_e w_st_next;
    logic      r_irq;

    // A major pulse always outweighs an acknowledge in the same cycle,
    // both in ACKED (re-arm) and in ALARM (stay raised).
    always_comb begin
        w_st_next = r_state;
        if (clr_i) begin
            w_st_next = ST_NORMAL;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_maj_any && (64'(w_tot_maj_next) >= 64'(MAJ_THR))) begin
                        w_st_next = ST_ALARM;
                    end
                end
                ST_ALARM: begin
                    if (irq_ack_i && !w_maj_any) begin
                        w_st_next = ST_ACKED;
                    end
                end
                ST_ACKED: begin
                    if (w_maj_any) begin
                        w_st_next = ST_ALARM;
                    end
                end
                default: w_st_next = ST_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_NORMAL;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_st_next;
            r_irq   <= (w_st_next == ST_ALARM);
        end
    end

    assign irq_o = r_irq;

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic             w_lane_ok;
    logic [IDX_W-1:0] w_idx;
    logic [TOT_W-1:0] w_rd_mux;
    logic             r_rd_valid;
    logic [TOT_W-1:0] r_rd_data;

    assign w_lane_ok = (32'(rd_idx_i) < NUM_MON);
    assign w_idx     = rd_idx_i[IDX_W-1:0];

    // Reads sample the counters' current values, so a read in the same
    // cycle as a pulse or a clear returns the value before that edge.
    always_comb begin
        w_rd_mux = '0;
        case (rd_sel_e'(rd_sel_i))
            RD_MIN: begin
                if (w_lane_ok) w_rd_mux = TOT_W'(w_min_cnt[w_idx]);
            end
            RD_MAJ: begin
                if (w_lane_ok) w_rd_mux = TOT_W'(w_maj_cnt[w_idx]);
            end
            RD_SCRUB: begin
`ifdef FATORI_FAULT_AGGR_SCRUB_CNT_EN
                if (w_lane_ok) w_rd_mux = TOT_W'(w_scrub_cnt[w_idx]);
`endif
            end
            RD_TOT_MIN: w_rd_mux = w_tot_min;
            RD_TOT_MAJ: w_rd_mux = w_tot_maj;
            RD_TOT_SCRUB: begin
`ifdef FATORI_FAULT_AGGR_SCRUB_CNT_EN
                w_rd_mux = w_tot_scrub;
`endif
            end
            RD_STATUS: w_rd_mux = TOT_W'(r_state);
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req_i;
            if (rd_req_i) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;

endmodule : fatori_fault_aggr
`default_nettype wire

// File: tb/tb_fatori_fault_aggr.sv
`default_nettype none
// ============================================================================
// Module   : tb_fatori_fault_aggr
// Purpose  : Self-checking bench for fatori_fault_aggr (scrub macro undefined).
//            A small reference model tracks counters, stickies and the alarm
//            state. Expected read data is queued when a read is issued and
//            compared when rd_valid_o returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fatori_fault_aggr;
    import fatori_fault_pkg::*;

    localparam int NM   = 4;
    localparam int CW   = 2;
    localparam int TW   = CW + $clog2(NM + 1);
    localparam int THR  = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [NM-1:0] min_p = '0;
    logic [NM-1:0] maj_p = '0;
    logic [NM-1:0] scr_p = '0;
    logic          clr = 1'b0;
    logic          rd_req = 1'b0;
    logic [2:0]    rd_sel = '0;
    logic [5:0]    rd_idx = '0;
    logic          ack = 1'b0;
    logic          rd_valid;
    logic [TW-1:0] rd_data;
    logic [NM-1:0] sticky;
    logic          irq;

    fatori_fault_aggr #(
        .NUM_MON (NM),
        .CNT_W   (CW),
        .TOT_W   (TW),
        .MAJ_THR (THR)
    ) u_dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .min_pulse_i   (min_p),
        .maj_pulse_i   (maj_p),
        .scrub_pulse_i (scr_p),
        .clr_i         (clr),
        .rd_req_i      (rd_req),
        .rd_sel_i      (rd_sel),
        .rd_idx_i      (rd_idx),
        .rd_valid_o    (rd_valid),
        .rd_data_o     (rd_data),
        .maj_sticky_o  (sticky),
        .irq_o         (irq),
        .irq_ack_i     (ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int            m_min [NM];
    int            m_maj [NM];
    int            m_tmin;
    int            m_tmaj;
    int            m_state;
    logic [NM-1:0] m_sticky;
    int            m_last;
    int            exp_q [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_min[i] = 0;
            m_maj[i] = 0;
        end
        m_tmin   = 0;
        m_tmaj   = 0;
        m_state  = int'(ST_NORMAL);
        m_sticky = '0;
        m_last   = 0;
    endtask

    function automatic int model_read(input int sel, input int idx);
        case (sel)
            0:       return (idx < NM) ? m_min[idx] : 0;
            1:       return (idx < NM) ? m_maj[idx] : 0;
            3:       return m_tmin;
            4:       return m_tmaj;
            6:       return m_state;
            default: return 0;
        endcase
    endfunction

    // One clock cycle with the currently driven inputs. The model is advanced
    // across the edge, one-shot inputs are dropped, and outputs are checked.
    task automatic step(input string lbl);
        int            n_min [NM];
        int            n_maj [NM];
        int            n_tmin;
        int            n_tmaj;
        int            n_st;
        logic [NM-1:0] n_sticky;
        bit            pushed;
        int            e;

        pushed = rd_req;
        if (rd_req) exp_q.push_back(model_read(int'(rd_sel), int'(rd_idx)));

        if (clr) begin
            for (int i = 0; i < NM; i++) begin
                n_min[i] = 0;
                n_maj[i] = 0;
            end
            n_tmin   = 0;
            n_tmaj   = 0;
            n_sticky = '0;
            n_st     = int'(ST_NORMAL);
        end else begin
            for (int i = 0; i < NM; i++) begin
                n_min[i] = m_min[i] + ((min_p[i] && m_min[i] < CMAX) ? 1 : 0);
                n_maj[i] = m_maj[i] + ((maj_p[i] && m_maj[i] < CMAX) ? 1 : 0);
            end
            n_tmin = m_tmin + $countones(min_p);
            if (n_tmin > TMAX) n_tmin = TMAX;
            n_tmaj = m_tmaj + $countones(maj_p);
            if (n_tmaj > TMAX) n_tmaj = TMAX;
            n_sticky = m_sticky | maj_p;
            n_st     = m_state;
            if (m_state == int'(ST_NORMAL)) begin
                if (maj_p != 0 && n_tmaj >= THR) n_st = int'(ST_ALARM);
            end else if (m_state == int'(ST_ALARM)) begin
                if (ack && maj_p == 0) n_st = int'(ST_ACKED);
            end else begin
                if (maj_p != 0) n_st = int'(ST_ALARM);
            end
        end

        @(posedge clk);
        #1;
        m_min    = n_min;
        m_maj    = n_maj;
        m_tmin   = n_tmin;
        m_tmaj   = n_tmaj;
        m_sticky = n_sticky;
        m_state  = n_st;
        min_p    = '0;
        maj_p    = '0;
        scr_p    = '0;
        clr      = 1'b0;
        ack      = 1'b0;
        rd_req   = 1'b0;

        chk({lbl, ":irq"}, irq, (m_state == int'(ST_ALARM)) ? 1 : 0);
        chk({lbl, ":sticky"}, sticky, m_sticky);
        chk({lbl, ":rd_valid"}, rd_valid, pushed ? 1 : 0);
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk({lbl, ":spurious_valid"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk({lbl, ":rd_data"}, rd_data, e);
                m_last = e;
            end
        end else begin
            chk({lbl, ":rd_hold"}, rd_data, m_last);
        end
    endtask

    task automatic rd(input string lbl, input int sel, input int idx);
        rd_req = 1'b1;
        rd_sel = 3'(sel);
        rd_idx = 6'(idx);
        step(lbl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Reset state.
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:irq", irq, 0);
        chk("reset:rd_valid", rd_valid, 0);
        chk("reset:rd_data", rd_data, 0);
        chk("reset:sticky", sticky, 0);
        arst_n = 1'b1;

        // Every select on lane 0 after reset, back to back.
        for (int s = 0; s < 8; s++) rd("rd_all", s, 0);

        // Three single major pulses reach MAJ_THR.
        maj_p = 4'b0001; step("maj0");
        maj_p = 4'b0010; step("maj1");
        maj_p = 4'b0100; step("maj2");
        rd("tot_maj", 4, 0);

        // Lane counter saturation, and the popcount total.
        repeat (5) begin
            min_p = 4'b0010;
            step("min1");
        end
        rd("min_sat", 0, 1);
        min_p = 4'b1111;
        rd("tot_min_pre", 3, 0);
        rd("tot_min_post", 3, 0);

        // Ack / re-raise, and ack racing a pulse.
        ack = 1'b1; step("ack");
        maj_p = 4'b1000; step("reraise");
        ack = 1'b1; maj_p = 4'b0001; step("ack_pulse_alarm");
        ack = 1'b1; step("ack2");
        ack = 1'b1; maj_p = 4'b0010; step("ack_pulse_acked");
        rd("status", 6, 0);

        // Clear with pulses in the same cycle; the read sees pre-clear data.
        clr = 1'b1; maj_p = 4'b1111; min_p = 4'b1111;
        rd("clr_read", 4, 0);
        rd("post_clr_tmaj", 4, 0);
        rd("post_clr_tmin", 3, 0);
        rd("post_clr_maj2", 1, 2);
        rd("post_clr_status", 6, 0);

        // Scrub pulses are ignored in this build.
        scr_p = 4'b1111; step("scrub");
        rd("scrub_lane", 2, 0);
        rd("scrub_tot", 5, 0);
        rd("sel7", 7, 0);

        // Out-of-range lane index.
        min_p = 4'b0001; step("min0");
        rd("idx_oob", 0, 5);
        rd("idx_ok", 0, 0);

        // Global total saturation.
        repeat (8) begin
            min_p = 4'b1111;
            step("tot_fill");
        end
        rd("tot_min_sat", 3, 0);

        // Asynchronous reset while read data is valid.
        rd("pre_areset", 3, 0);
        #2;
        arst_n = 1'b0;
        #1;
        chk("areset:rd_valid", rd_valid, 0);
        chk("areset:rd_data", rd_data, 0);
        chk("areset:irq", irq, 0);
        model_reset();
        exp_q.delete();
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        rd("after_areset", 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fatori_fault_aggr
`default_nettype wire
